cryptoveril_decrypt: RTL and testbench

- Iterative decryptor: the receive-side inverse of the cryptoveril encryption path.
- Takes a 16-bit ciphertext word and the 5-bit key, and recovers the plaintext by undoing ROUNDS cipher rounds in reverse order.
- Single clock domain, with a valid/ready handshake on both input and output.
- Sits downstream of the cryptoveril output link and feeds plaintext consumers.

---
 rtl/cryptoveril_decrypt.sv | 112 +++++++++++
 tb/tb_cryptoveril_decrypt.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cryptoveril_decrypt.sv
// Iterative decryptor: undoes ROUNDS rotate/xor rounds of the cryptoveril cipher.
// Optional even-parity check on the ciphertext when CRYPTOVERIL_DEC_PARITY_EN is defined.
module cryptoveril_decrypt #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [4:0]  key_bits,
`ifdef CRYPTOVERIL_DEC_PARITY_EN
  input  logic        in_parity,
  output logic        out_parity_err,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  localparam int unsigned CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   data_q, data_d;
  logic [15:0]   out_q, out_d;
  logic [4:0]    key_q, key_d;
  logic          perr_q, perr_d;

  logic [15:0] rk, x, dec;
  logic [3:0]  sh;
  logic [31:0] dbl;

  // One decrypt round for the current counter value.
  always_comb begin
    rk  = {key_q, key_q, key_q, key_q[4]} ^ (16'(cnt_q) * 16'h1111);
    sh  = key_q[3:0] + 4'(cnt_q);
    x   = data_q ^ rk;
    dbl = {x, x} >> sh;
    dec = dbl[15:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    out_d   = out_q;
    key_d   = key_q;
    perr_d  = perr_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          key_d   = key_bits;
          cnt_d   = CW'(ROUNDS - 1);
          state_d = StRun;
`ifdef CRYPTOVERIL_DEC_PARITY_EN
          perr_d  = in_parity != ^in_data;
`else
          perr_d  = 1'b0;
`endif
        end
      end
      StRun: begin
        data_d = dec;
        if (cnt_q == '0) begin
          out_d   = dec;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      out_q   <= '0;
      key_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      out_q   <= out_d;
      key_q   <= key_d;
      perr_q  <= perr_d;
    end
  end

  assign in_ready  = state_q == StIdle;
  assign out_valid = state_q == StDone;
  assign busy      = state_q != StIdle;
  // Separate output register so out_data holds between results while data_q iterates.
  assign out_data  = out_q;
`ifdef CRYPTOVERIL_DEC_PARITY_EN
  assign out_parity_err = out_valid & perr_q;
`endif

endmodule

// File: tb/tb_cryptoveril_decrypt.sv
// Directed bench: three decryptor instances (ROUNDS = 1, 4, 8) against an encryption model.
module tb_cryptoveril_decrypt;

  logic        clk;
  logic        rst;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] in_data   [3];
  logic [4:0]  key_bits  [3];
  logic        in_parity [3];
  logic        perr      [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [15:0] out_data  [3];
  logic        busy      [3];

  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cryptoveril_decrypt #(.ROUNDS((g == 0) ? 1 : ((g == 1) ? 4 : 8))) u_dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid[g]),
      .in_ready      (in_ready[g]),
      .in_data       (in_data[g]),
      .key_bits      (key_bits[g]),
`ifdef CRYPTOVERIL_DEC_PARITY_EN
      .in_parity     (in_parity[g]),
      .out_parity_err(perr[g]),
`endif
      .out_valid     (out_valid[g]),
      .out_ready     (out_ready[g]),
      .out_data      (out_data[g]),
      .busy          (busy[g])
    );
`ifndef CRYPTOVERIL_DEC_PARITY_EN
    assign perr[g] = 1'b0;
`endif
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rotl(input logic [15:0] d, input logic [3:0] s);
    logic [31:0] t;
    t = {d, d} << s;
    return t[31:16];
  endfunction

  function automatic logic [15:0] enc(input logic [15:0] d, input logic [4:0] k, input int rounds);
    logic [15:0] v, rk;
    logic [3:0]  s;
    v = d;
    for (int r = 0; r < rounds; r++) begin
      rk = {k, k, k, k[4]} ^ 16'(r * 32'h1111);
      s  = 4'(k[3:0] + 4'(r));
      v  = rotl(v, s) ^ rk;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Accept one word on instance idx; returns at #1 after the edge where out_valid is seen.
  task automatic run(input int idx, input logic [15:0] d, input logic [4:0] k,
                     output logic [15:0] got, output int lat);
    int w;
    w = 0;
    while (!in_ready[idx] && w < 40) begin
      @(posedge clk); #1; w++;
    end
    in_data[idx]  = d;
    key_bits[idx] = k;
    in_valid[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    in_data[idx]  = ~d;
    key_bits[idx] = ~k;
    in_parity[idx] = ~in_parity[idx];
    lat = 0;
    while (!out_valid[idx] && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid[idx]) lat = -1;
    got = out_data[idx];
  endtask

  typedef struct {
    int          inst;
    logic [15:0] din;
    logic [4:0]  key;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] got, pt, ct;
  logic [4:0]  kk;
  int          lat;
  int          rnd_fail;

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; key_bits[i] = '0;
      in_parity[i] = 1'b0; out_ready[i] = 1'b1;
    end

    vecs[0] = '{0, 16'hBEEF, 5'h00, 16'hBEEF, 1};
    vecs[1] = '{0, 16'h0842, 5'h01, 16'h0000, 1};
    vecs[2] = '{0, 16'h0843, 5'h01, 16'h8000, 1};
    vecs[3] = '{1, enc(16'h1234, 5'h1B, 4), 5'h1B, 16'h1234, 4};
    vecs[4] = '{1, enc(16'hFFFF, 5'h1F, 4), 5'h1F, 16'hFFFF, 4};
    vecs[5] = '{2, enc(16'hA5A5, 5'h07, 8), 5'h07, 16'hA5A5, 8};

    #12;
    for (int i = 0; i < 3; i++) begin
      chk("reset_in_ready", 32'(in_ready[i]), 32'd1);
      chk("reset_out_valid", 32'(out_valid[i]), 32'd0);
      chk("reset_out_data", 32'(out_data[i]), 32'h0);
      chk("reset_busy", 32'(busy[i]), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run(vecs[i].inst, vecs[i].din, vecs[i].key, got, lat);
      chk("vec_out_data", 32'(got), 32'(vecs[i].exp));
      chk("vec_latency", 32'(lat), 32'(vecs[i].lat));
      chk("vec_busy_done", 32'(busy[vecs[i].inst]), 32'd1);
      @(posedge clk); #1;
      chk("vec_out_valid_drop", 32'(out_valid[vecs[i].inst]), 32'd0);
      chk("vec_in_ready_back", 32'(in_ready[vecs[i].inst]), 32'd1);
      chk("vec_out_data_held", 32'(out_data[vecs[i].inst]), 32'(vecs[i].exp));
    end

    // Random loopback sweep on ROUNDS=4.
    rnd_fail = 0;
    for (int i = 0; i < 256; i++) begin
      pt = 16'($urandom);
      kk = 5'($urandom);
      run(1, enc(pt, kk, 4), kk, got, lat);
      chk("sweep_roundtrip", 32'(got), 32'(pt));
      @(posedge clk); #1;
    end

    // Backpressure: hold DONE for 10 cycles while wiggling inputs.
    out_ready[1] = 1'b0;
    run(1, enc(16'hC0DE, 5'h15, 4), 5'h15, got, lat);
    chk("bp_first", 32'(got), 32'hC0DE);
    for (int c = 0; c < 10; c++) begin
      key_bits[1] = 5'($urandom);
      in_data[1]  = 16'($urandom);
      in_valid[1] = 1'b1;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid[1]), 32'd1);
      chk("bp_out_data", 32'(out_data[1]), 32'hC0DE);
      chk("bp_in_ready", 32'(in_ready[1]), 32'd0);
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid[1]), 32'd0);
    chk("bp_release_data", 32'(out_data[1]), 32'hC0DE);

    // Mid-run reset on ROUNDS=8, three cycles after accept.
    in_data[2] = enc(16'h5A5A, 5'h0C, 8); key_bits[2] = 5'h0C; in_valid[2] = 1'b1;
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid[2]), 32'd0);
    chk("mrst_out_data", 32'(out_data[2]), 32'h0);
    chk("mrst_in_ready", 32'(in_ready[2]), 32'd1);
    chk("mrst_busy", 32'(busy[2]), 32'd0);
    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    run(2, enc(16'h7E57, 5'h13, 8), 5'h13, got, lat);
    chk("mrst_after_data", 32'(got), 32'h7E57);
    chk("mrst_after_lat", 32'(lat), 32'd8);
    @(posedge clk); #1;

`ifdef CRYPTOVERIL_DEC_PARITY_EN
    in_parity[1] = 1'b0;
    run(1, 16'h0001, 5'h00, got, lat);
    chk("parity_err_set", 32'(perr[1]), 32'd1);
    @(posedge clk); #1;
    chk("parity_err_idle", 32'(perr[1]), 32'd0);
    in_parity[1] = 1'b1;
    run(1, 16'h0001, 5'h00, got, lat);
    chk("parity_err_clear", 32'(perr[1]), 32'd0);
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
